// File: rtl/nn_pkg.sv
// nn_pkg: lane constants and FSM encodings shared by the softmax and argmax stages
package nn_pkg;
  localparam int N_CLASSES = 10;
  localparam int DATA_W = 16;
  localparam logic [15:0] Q15_ONE = 16'h8000;
  localparam logic [15:0] CONF_THRESH_Q15 = 16'h4000;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/argmax_cmp_cell.sv
// argmax_cmp_cell: combinational top-2 update of one lane; strict compare keeps the lowest index on ties
module argmax_cmp_cell #(
  parameter int DATA_W = 16,
  parameter int IDX_W = 4
) (
  input  logic [DATA_W-1:0] v,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] best,
  input  logic [DATA_W-1:0] second,
  input  logic [IDX_W-1:0]  best_idx,
  output logic [DATA_W-1:0] best_nxt,
  output logic [DATA_W-1:0] second_nxt,
  output logic [IDX_W-1:0]  best_idx_nxt
);
  always_comb begin
    best_nxt = v > best ? v : best;
    second_nxt = v > best ? best : (v > second ? v : second);
    best_idx_nxt = v > best ? idx : best_idx;
  end
endmodule

// File: rtl/argmax_classifier.sv
// argmax_classifier: serial argmax/margin scan of a Q1.15 probability vector; ARGMAX_STATS_EN adds per-class decision counters
module argmax_classifier
  import nn_pkg::*;
#(
  parameter int N_CLASSES = nn_pkg::N_CLASSES,
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter logic [DATA_W-1:0] CONF_THRESH = DATA_W'(nn_pkg::CONF_THRESH_Q15)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CLASSES*DATA_W-1:0]   prob_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [3:0]                    class_idx,
  output logic [DATA_W-1:0]             best_prob,
  output logic [DATA_W-1:0]             margin,
  output logic                          low_conf,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overrun,
  input  logic [3:0]                    stat_sel,
  output logic [15:0]                   stat_count
);
  localparam logic [3:0] LAST = 4'(N_CLASSES - 1);
  if (N_CLASSES < 1 || N_CLASSES > 16) begin : g_bad_n
    $error("argmax_classifier: N_CLASSES must be in 1..16");
  end
  state_t state, state_nxt;
  logic [N_CLASSES*DATA_W-1:0] prob_q;
  logic [3:0] idx, best_idx, best_idx_nxt;
  logic [DATA_W-1:0] best, second, best_nxt, second_nxt, lane;
  assign lane = prob_q[idx*DATA_W +: DATA_W];
  argmax_cmp_cell #(.DATA_W(DATA_W), .IDX_W(4)) u_cell (
    .v(lane),
    .idx(idx),
    .best(best),
    .second(second),
    .best_idx(best_idx),
    .best_nxt(best_nxt),
    .second_nxt(second_nxt),
    .best_idx_nxt(best_idx_nxt)
  );
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE ? (in_valid ? SCAN : IDLE)
              : state == SCAN ? (idx == LAST ? HOLD : SCAN)
              : state == HOLD ? (out_ready ? IDLE : HOLD)
              : IDLE;
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == HOLD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prob_q <= '0;
      idx <= '0;
      best <= '0;
      second <= '0;
      best_idx <= '0;
      class_idx <= '0;
      best_prob <= '0;
      margin <= '0;
      low_conf <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (in_valid && !in_ready) overrun <= 1'b1;
      if (state == IDLE && in_valid) begin
        prob_q <= prob_in;
        idx <= '0;
        best <= '0;
        second <= '0;
        best_idx <= '0;
      end else if (state == SCAN) begin
        idx <= idx + 4'd1;
        best <= best_nxt;
        second <= second_nxt;
        best_idx <= best_idx_nxt;
        // result registers load only on the last lane so they hold through HOLD and beyond
        if (idx == LAST) begin
          class_idx <= best_idx_nxt;
          best_prob <= best_nxt;
          margin <= best_nxt - second_nxt;
          low_conf <= best_nxt < CONF_THRESH;
        end
      end
    end
  end
`ifdef ARGMAX_STATS_EN
  logic [15:0] cnt [N_CLASSES];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CLASSES; i++) cnt[i] <= '0;
      stat_count <= '0;
    end else begin
      if (out_valid && out_ready && cnt[class_idx] != 16'hFFFF) cnt[class_idx] <= cnt[class_idx] + 16'd1;
      stat_count <= 32'(stat_sel) < N_CLASSES ? cnt[stat_sel] : '0;
    end
  end
`else
  logic stat_sel_unused;
  assign stat_sel_unused = ^stat_sel;
  assign stat_count = '0;
`endif
endmodule

// File: tb/tb_argmax_classifier.sv
// tb_argmax_classifier: directed and random vectors against a max/second-max reference model
module tb_argmax_classifier;
  localparam int N = 10;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [N*W-1:0] prob_in = '0;
  logic [3:0] stat_sel = '0;
  logic in_ready, out_valid, low_conf, overrun;
  logic [3:0] class_idx;
  logic [W-1:0] best_prob, margin;
  logic [15:0] stat_count;
  int tests = 0;
  int fails = 0;
  int exp_cnt [16];
  logic [15:0] lanes [N];
  logic [3:0] e_idx;
  logic [W-1:0] e_best, e_margin;
  logic e_low;
  always #5 clk = ~clk;
  argmax_classifier dut (
    .clk(clk),
    .rst(rst),
    .prob_in(prob_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .class_idx(class_idx),
    .best_prob(best_prob),
    .margin(margin),
    .low_conf(low_conf),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun(overrun),
    .stat_sel(stat_sel),
    .stat_count(stat_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [N*W-1:0] pack_lanes();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = lanes[k];
    return v;
  endfunction
  task automatic model();
    logic [W-1:0] sec;
    e_idx = '0;
    e_best = lanes[0];
    for (int k = 1; k < N; k++) if (lanes[k] > e_best) begin
      e_best = lanes[k];
      e_idx = 4'(k);
    end
    sec = '0;
    for (int k = 0; k < N; k++) if (k != int'(e_idx) && lanes[k] > sec) sec = lanes[k];
    e_margin = e_best - sec;
    e_low = e_best < 16'h4000;
  endtask
  task automatic issue();
    @(negedge clk);
    prob_in = pack_lanes();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic check_result(input string tag);
    check({tag, ".idx"}, 32'(class_idx), 32'(e_idx));
    check({tag, ".best"}, 32'(best_prob), 32'(e_best));
    check({tag, ".margin"}, 32'(margin), 32'(e_margin));
    check({tag, ".low"}, 32'(low_conf), 32'(e_low));
  endtask
  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt[e_idx]++;
    check({tag, ".drop_valid"}, 32'(out_valid), 0);
    check({tag, ".ready"}, 32'(in_ready), 1);
  endtask
  task automatic run_vec(input string tag);
    int lat;
    model();
    issue();
    wait_valid(lat);
    check({tag, ".latency"}, lat, N + 1);
    check_result(tag);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check({tag, ".still_valid"}, 32'(out_valid), 1);
    accept(tag);
  endtask
  initial begin
    int lat;
    logic stable;
    for (int i = 0; i < 16; i++) exp_cnt[i] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst.in_ready", 32'(in_ready), 1);
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.idx", 32'(class_idx), 0);
    check("rst.best", 32'(best_prob), 0);
    check("rst.margin", 32'(margin), 0);
    check("rst.low", 32'(low_conf), 0);
    check("rst.overrun", 32'(overrun), 0);
    check("rst.stat", 32'(stat_count), 0);
    lanes = '{16'h0100, 16'h0200, 16'h6000, 16'h0300, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};
    run_vec("t1");
    check("t1.idx_const", 32'(class_idx), 2);
    check("t1.margin_const", 32'(margin), 32'h5D00);
    for (int k = 0; k < N; k++) lanes[k] = 16'h0400;
    lanes[3] = 16'h3000;
    lanes[7] = 16'h3000;
    run_vec("t2");
    check("t2.idx_const", 32'(class_idx), 3);
    check("t2.margin_const", 32'(margin), 0);
    for (int k = 0; k < N; k++) lanes[k] = 16'h0000;
    run_vec("t3");
    check("t3.low_const", 32'(low_conf), 1);
    for (int k = 0; k < N; k++) lanes[k] = 16'($urandom_range(0, 16'h8000));
    model();
    issue();
    wait_valid(lat);
    check("t4.latency", lat, N + 1);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!out_valid || class_idx !== e_idx || best_prob !== e_best || margin !== e_margin || low_conf !== e_low) stable = 1'b0;
      if (i == 5) for (int k = 0; k < N; k++) prob_in[k*W +: W] = 16'($urandom);
      in_valid = i == 5;
    end
    in_valid = 1'b0;
    check("t4.stable", 32'(stable), 1);
    check("t4.overrun", 32'(overrun), 1);
    check_result("t4");
    accept("t4");
    @(negedge clk);
    check("t4.no_extra", 32'(out_valid), 0);
    for (int k = 0; k < N; k++) lanes[k] = 16'($urandom_range(0, 16'h8000));
    issue();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) exp_cnt[i] = 0;
    check("t5.out_valid", 32'(out_valid), 0);
    check("t5.in_ready", 32'(in_ready), 1);
    check("t5.idx", 32'(class_idx), 0);
    check("t5.best", 32'(best_prob), 0);
    check("t5.margin", 32'(margin), 0);
    check("t5.overrun", 32'(overrun), 0);
    lanes = '{16'h0100, 16'h0200, 16'h6000, 16'h0300, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};
    run_vec("t5b");
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) lanes[k] = 16'($urandom_range(0, 16'h0FFF));
      lanes[4] = 16'h7000;
      run_vec("t6");
    end
    @(negedge clk);
    stat_sel = 4'd4;
    @(negedge clk);
`ifdef ARGMAX_STATS_EN
    check("t6.count4", 32'(stat_count), 3);
`else
    check("t6.count_off", 32'(stat_count), 0);
`endif
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < N; k++) lanes[k] = r % 2 == 0 ? 16'($urandom_range(0, 16'h8000)) : 16'($urandom_range(0, 3) * 16'h1800);
      run_vec("rnd");
    end
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      stat_sel = 4'(s);
      @(negedge clk);
`ifdef ARGMAX_STATS_EN
      check("stat.sweep", 32'(stat_count), s < N ? exp_cnt[s] : 0);
`else
      check("stat.off", 32'(stat_count), 0);
`endif
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
